// File: rtl/sseg_pkg.sv
// Shared 7-segment definitions: glyph table, bit positions, receiver state type.
// Encoder and decoder both use HEX_GLYPH, so the two cannot disagree.
package sseg_pkg;

    localparam logic [7:0] SSEG_BLANK = 8'hFF;
    localparam logic [7:0] SSEG_MINUS = 8'hFE;
    localparam int         SEG_DP     = 7;
    localparam int         SEG_G      = 0;

    // Active-low glyphs, bit6 = a ... bit0 = g
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic {
        SETTLE = 1'b0,
        HELD   = 1'b1
    } rx_state_t;

    function automatic logic an_is_valid(input logic [3:0] an);
        return (an == 4'hE) || (an == 4'hD) || (an == 4'hB) || (an == 4'h7);
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        if (!an[1]) idx = 2'd1;
        if (!an[2]) idx = 2'd2;
        if (!an[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/sseg_to_hex.sv
// Purpose: map a 7-bit active-low segment pattern back to its hex nibble.
// Latency: combinational.
// Backpressure: none; non-glyph patterns give hex 0 with ok low.
module sseg_to_hex
    import sseg_pkg::*;
(
    input  logic [SEG_DP-1:SEG_G] pat,
    output logic [3:0]            hex,
    output logic                  ok
);

    always_comb begin
        hex = 4'h0;
        ok  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pat == HEX_GLYPH[i]) begin
                hex = 4'(i);
                ok  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sseg_scan_rx.sv
// Purpose: rebuild a consistent 4-digit frame from the multiplexed an/sseg bus.
// Latency: capture after STABLE_CYC+1 identical samples; outputs update with frame_tick.
// Backpressure: none; the bus is sampled every cycle and glitches are filtered.
module sseg_scan_rx
    import sseg_pkg::*;
#(
    parameter int STABLE_CYC = 16,
    parameter int TIMEOUT_W  = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  sseg,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic [7:0]  seg3,
    output logic [15:0] hex_out,
    output logic [3:0]  hex_ok,
    output logic        frame_tick,
    output logic        stale
);

    localparam int                   CNT_W   = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0]     CAP_CNT = CNT_W'(STABLE_CYC - 1);
    localparam logic [TIMEOUT_W-1:0] TO_MAX  = '1;

    logic [3:0]           an_r;
    logic [7:0]           sseg_r;
    logic [CNT_W-1:0]     cnt;
    rx_state_t            state, state_nxt;
    logic [7:0]           dig_buf [4];
    logic [7:0]           seg_nxt [4];
    logic [3:0]           mask;
    logic [TIMEOUT_W-1:0] tcnt, tcnt_nxt;
    logic                 match, capture, frame_done;
    logic [1:0]           cap_idx;
    logic [3:0]           cap_bit;
    logic [15:0]          dec_hex;
    logic [3:0]           dec_ok;

    assign match      = ({an, sseg} == {an_r, sseg_r});
    assign cap_idx    = an_index(an_r);
    assign cap_bit    = 4'b0001 << cap_idx;
    assign frame_done = capture && ((mask | cap_bit) == 4'hF);
    assign tcnt_nxt   = frame_done ? '0 : ((tcnt == TO_MAX) ? tcnt : tcnt + 1'b1);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            SETTLE: begin
                if (match && (cnt == CAP_CNT) && an_is_valid(an_r)) begin
                    capture   = 1'b1;
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (!match) state_nxt = SETTLE;
            end
            default: state_nxt = SETTLE;
        endcase
    end

    // Buffer view including this edge's capture, so a completing frame is whole
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            seg_nxt[i] = (capture && (cap_idx == 2'(i))) ? sseg_r : dig_buf[i];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_dec
        sseg_to_hex u_dec (
            .pat (seg_nxt[g][SEG_DP-1:SEG_G]),
            .hex (dec_hex[g*4 +: 4]),
            .ok  (dec_ok[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_r       <= 4'hF;
            sseg_r     <= SSEG_BLANK;
            cnt        <= '0;
            state      <= SETTLE;
            mask       <= 4'h0;
            tcnt       <= '0;
            stale      <= 1'b1;
            frame_tick <= 1'b0;
            hex_out    <= 16'h0;
            hex_ok     <= 4'h0;
            seg0       <= SSEG_BLANK;
            seg1       <= SSEG_BLANK;
            seg2       <= SSEG_BLANK;
            seg3       <= SSEG_BLANK;
            for (int i = 0; i < 4; i++) dig_buf[i] <= SSEG_BLANK;
        end else begin
            an_r   <= an;
            sseg_r <= sseg;
            if (!match)             cnt <= '0;
            else if (cnt != '1)     cnt <= cnt + 1'b1;
            state      <= state_nxt;
            tcnt       <= tcnt_nxt;
            frame_tick <= frame_done;
            for (int i = 0; i < 4; i++) dig_buf[i] <= seg_nxt[i];
            // Completion clears the mask even though a bit is being set this edge
            if (frame_done) begin
                mask    <= 4'h0;
                seg0    <= seg_nxt[0];
                seg1    <= seg_nxt[1];
                seg2    <= seg_nxt[2];
                seg3    <= seg_nxt[3];
                hex_out <= dec_hex;
                hex_ok  <= dec_ok;
                stale   <= 1'b0;
            end else begin
                if (capture)            mask  <= mask | cap_bit;
                if (tcnt_nxt == TO_MAX) stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_rx.sv
// Directed bench for sseg_scan_rx with STABLE_CYC = 4 and TIMEOUT_W = 6.
module tb_sseg_scan_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic [7:0]  seg0, seg1, seg2, seg3;
    logic [15:0] hex_out;
    logic [3:0]  hex_ok;
    logic        frame_tick;
    logic        stale;

    always #5 clk = ~clk;

    sseg_scan_rx #(.STABLE_CYC(4), .TIMEOUT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .an         (an),
        .sseg       (sseg),
        .seg0       (seg0),
        .seg1       (seg1),
        .seg2       (seg2),
        .seg3       (seg3),
        .hex_out    (hex_out),
        .hex_ok     (hex_ok),
        .frame_tick (frame_tick),
        .stale      (stale)
    );

    typedef struct {
        logic [31:0] segs;
        logic [15:0] hex;
        logic [3:0]  ok;
    } frame_vec_t;

    frame_vec_t tbl [5];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ticks = 0;
    int   last_tick = -1;
    int   a7, t0, tk, n;
    logic stale_prev = 1'b1;
    logic stale_at_tick = 1'b1;
    logic stale_before_tick = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (frame_tick) begin
            ticks++;
            last_tick         = cyc;
            stale_at_tick     = stale;
            stale_before_tick = stale_prev;
        end
        stale_prev = stale;
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int cycles);
        an   = a;
        sseg = s;
        repeat (cycles) step();
    endtask

    // Scans E,D,B then 7; returns the cycle at which an = 7 was applied.
    task automatic scan(input logic [31:0] segs, output int apply7);
        for (int d = 0; d < 3; d++) hold(4'(~(4'b0001 << d)), segs[d*8 +: 8], 10);
        apply7 = cyc;
        hold(4'h7, segs[31:24], 10);
    endtask

    task automatic frame_check(input string name, input int tick0, input int apply7,
                               input logic [31:0] segs, input logic [15:0] hx,
                               input logic [3:0] ok);
        check({name, " ticks"}, 32'(ticks - tick0), 32'd1);
        check({name, " tick_delay"}, 32'(last_tick - apply7), 32'd5);
        check({name, " segs"}, {seg3, seg2, seg1, seg0}, segs);
        check({name, " hex_out"}, 32'(hex_out), 32'(hx));
        check({name, " hex_ok"}, 32'(hex_ok), 32'(ok));
        check({name, " stale"}, 32'(stale), 32'd0);
    endtask

    initial begin
        tbl[0] = '{32'h888F_FE86, 16'hA703, 4'b1101};
        tbl[1] = '{32'hCC92_CF81, 16'h4210, 4'b1111};
        tbl[2] = '{32'h8480_A024, 16'h9865, 4'b1111};
        tbl[3] = '{32'hB0C2_B1E0, 16'hEDCB, 4'b1111};
        tbl[4] = '{32'h8FD5_FFB8, 16'h700F, 4'b1001};

        reset = 1'b1;
        an    = 4'hF;
        sseg  = 8'hFF;
        step();
        step();
        check("reset segs", {seg3, seg2, seg1, seg0}, 32'hFFFF_FFFF);
        check("reset hex_out", 32'(hex_out), 32'h0);
        check("reset hex_ok", 32'(hex_ok), 32'h0);
        check("reset frame_tick", 32'(frame_tick), 32'h0);
        check("reset stale", 32'(stale), 32'h1);
        reset = 1'b0;

        hold(4'hF, 8'hFF, 100);
        check("idle ticks", 32'(ticks), 32'd0);
        check("idle segs", {seg3, seg2, seg1, seg0}, 32'hFFFF_FFFF);
        check("idle hex_ok", 32'(hex_ok), 32'h0);
        check("idle stale", 32'(stale), 32'h1);

        for (int f = 0; f < 5; f++) begin
            t0 = ticks;
            scan(tbl[f].segs, a7);
            frame_check($sformatf("frame%0d", f), t0, a7, tbl[f].segs, tbl[f].hex, tbl[f].ok);
        end

        // 3-cycle glitch on digit 0 is filtered out
        t0 = ticks;
        hold(4'hE, 8'h81, 10);
        hold(4'hD, 8'hCF, 10);
        hold(4'hE, 8'h80, 3);
        hold(4'hB, 8'h92, 10);
        a7 = cyc;
        hold(4'h7, 8'hCC, 10);
        frame_check("glitch", t0, a7, 32'hCC92_CF81, 16'h4210, 4'hF);

        // STABLE_CYC+1 samples is enough: digit 0 is re-captured and overwritten
        t0 = ticks;
        hold(4'hE, 8'h81, 10);
        hold(4'hD, 8'hCF, 10);
        hold(4'hE, 8'h80, 5);
        hold(4'hB, 8'h92, 10);
        a7 = cyc;
        hold(4'h7, 8'hCC, 10);
        frame_check("recapture", t0, a7, 32'hCC92_CF80, 16'h4218, 4'hF);

        // Two anodes low for a long time: ignored, mask intact
        t0 = ticks;
        hold(4'hE, 8'hB8, 10);
        hold(4'hD, 8'hFF, 10);
        hold(4'b1100, 8'h88, 50);
        check("invalid_an ticks", 32'(ticks - t0), 32'd0);
        check("invalid_an segs", {seg3, seg2, seg1, seg0}, 32'hCC92_CF80);
        hold(4'hB, 8'hD5, 10);
        a7 = cyc;
        hold(4'h7, 8'h8F, 10);
        frame_check("invalid_an", t0, a7, tbl[4].segs, tbl[4].hex, tbl[4].ok);

        // Partial frame discarded by reset
        t0 = ticks;
        hold(4'hD, 8'h86, 10);
        hold(4'hB, 8'h86, 10);
        hold(4'h7, 8'h86, 10);
        check("partial ticks", 32'(ticks - t0), 32'd0);
        reset = 1'b1;
        step();
        check("midreset segs", {seg3, seg2, seg1, seg0}, 32'hFFFF_FFFF);
        check("midreset stale", 32'(stale), 32'h1);
        reset = 1'b0;
        t0 = ticks;
        scan(tbl[1].segs, a7);
        frame_check("post_reset", t0, a7, tbl[1].segs, tbl[1].hex, tbl[1].ok);

        // Stale timeout: 2^6-1 cycles after the completing edge
        tk = last_tick;
        an   = 4'hF;
        sseg = 8'hFF;
        n = 0;
        while (!stale && n < 200) begin
            step();
            n++;
        end
        check("timeout stale", 32'(stale), 32'h1);
        check("timeout delay", 32'(cyc - tk), 32'd63);
        t0 = ticks;
        scan(tbl[2].segs, a7);
        check("stale before tick", 32'(stale_before_tick), 32'h1);
        check("stale at tick", 32'(stale_at_tick), 32'h0);
        frame_check("after_timeout", t0, a7, tbl[2].segs, tbl[2].hex, tbl[2].ok);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
